// File: rtl/vote_round_ctrl_if.sv
// vote_round_ctrl_if: voter request/ballot/grant lines and result handshake.
// VOTE_QUORUM_CHECK_EN adds the no_quorum status line.
interface vote_round_ctrl_if;
    logic       start;
    logic [2:0] req;
    logic [2:0] ballot;
    logic [2:0] gnt;
    logic       busy;
    logic [2:0] vote_mask;
    logic       result;
    logic       result_valid;
    logic       result_ready;
    logic       timeout_flag;
`ifdef VOTE_QUORUM_CHECK_EN
    logic       no_quorum;

    modport master (
        output start, req, ballot, result_ready,
        input  gnt, busy, vote_mask, result, result_valid, timeout_flag,
        input  no_quorum
    );

    modport slave (
        input  start, req, ballot, result_ready,
        output gnt, busy, vote_mask, result, result_valid, timeout_flag,
        output no_quorum
    );
`else
    modport master (
        output start, req, ballot, result_ready,
        input  gnt, busy, vote_mask, result, result_valid, timeout_flag
    );

    modport slave (
        input  start, req, ballot, result_ready,
        output gnt, busy, vote_mask, result, result_valid, timeout_flag
    );
`endif
endinterface

// File: rtl/vote_round_ctrl.sv
// vote_round_ctrl: round-robin ballot collection into one shared majority gate.
// Optional VOTE_QUORUM_CHECK_EN: no_quorum output, result forced 0 without quorum.
module vote_round_ctrl #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    vote_round_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EVAL,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [1:0] rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [2:0] gnt_q;
    logic [2:0] mask_q;
    logic [2:0] ballot_q;
    logic       busy_q;
    logic       result_q;
    logic       valid_q;
    logic       tflag_q;

    logic [2:0] accept;
    logic [2:0] mask_nxt;
    logic [1:0] rr_nxt;
    logic [2:0] gnt_nxt;
    logic       maj_w;

    function automatic logic maj(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // circular first-set search starting at position p
    function automatic logic [2:0] pick(input logic [2:0] c,
                                        input logic [1:0] p);
        logic [2:0] g;
        g = 3'b000;
        case (p)
            2'd1: begin
                if (c[1])      g = 3'b010;
                else if (c[2]) g = 3'b100;
                else if (c[0]) g = 3'b001;
            end
            2'd2: begin
                if (c[2])      g = 3'b100;
                else if (c[0]) g = 3'b001;
                else if (c[1]) g = 3'b010;
            end
            default: begin
                if (c[0])      g = 3'b001;
                else if (c[1]) g = 3'b010;
                else if (c[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

    assign accept   = gnt_q & bus.req;
    assign mask_nxt = mask_q | accept;
    assign gnt_nxt  = pick(bus.req & ~mask_nxt, rr_nxt);
    assign maj_w    = maj(ballot_q);

    always_comb begin
        rr_nxt = rr_ptr;
        unique case (1'b1)
            accept[0]: rr_nxt = 2'd1;
            accept[1]: rr_nxt = 2'd2;
            accept[2]: rr_nxt = 2'd0;
            default:   rr_nxt = rr_ptr;
        endcase
    end

`ifdef VOTE_QUORUM_CHECK_EN
    logic nq_q;
    logic nq_w;

    // fewer than two accepted voters is exactly a zero majority of the mask
    assign nq_w          = ~maj(mask_q);
    assign bus.no_quorum = nq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nq_q <= 1'b0;
        end else if (state == EVAL) begin
            nq_q <= nq_w;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            cnt      <= '0;
            gnt_q    <= 3'b000;
            mask_q   <= 3'b000;
            ballot_q <= 3'b000;
            busy_q   <= 1'b0;
            result_q <= 1'b0;
            valid_q  <= 1'b0;
            tflag_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= COLLECT;
                        busy_q   <= 1'b1;
                        gnt_q    <= 3'b000;
                        mask_q   <= 3'b000;
                        ballot_q <= 3'b000;
                        cnt      <= '0;
                        tflag_q  <= 1'b0;
                    end
                end
                COLLECT: begin
                    cnt      <= cnt + CNT_W'(1);
                    mask_q   <= mask_nxt;
                    rr_ptr   <= rr_nxt;
                    ballot_q <= (ballot_q & ~accept) |
                                (bus.ballot & accept);
                    if (mask_nxt == 3'b111) begin
                        state <= EVAL;
                        gnt_q <= 3'b000;
                    end else if (cnt == CNT_LAST) begin
                        state   <= EVAL;
                        gnt_q   <= 3'b000;
                        tflag_q <= 1'b1;
                    end else begin
                        gnt_q <= gnt_nxt;
                    end
                end
                EVAL: begin
`ifdef VOTE_QUORUM_CHECK_EN
                    result_q <= maj_w & ~nq_w;
`else
                    result_q <= maj_w;
`endif
                    valid_q  <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (bus.result_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.busy         = busy_q;
    assign bus.vote_mask    = mask_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.timeout_flag = tflag_q;

endmodule

// File: tb/tb_vote_round_ctrl.sv
// tb_vote_round_ctrl: table rounds, hold/reset sequences, random rounds
// against a round-level reference model.
module tb_vote_round_ctrl;

    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vote_round_ctrl_if bus();

    vote_round_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int nchecks = 0;
    int nerrors = 0;

    logic [2:0] gseq [0:63];
    int ncol;

    typedef struct {
        logic [2:0] req;
        logic [2:0] ballot;
        logic [2:0] first_gnt;
        int         cycles;
        logic       res;
        logic [2:0] mask;
        logic       tflag;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, " gnt"}, 32'(bus.gnt), 0);
        chk({tag, " busy"}, 32'(bus.busy), 0);
        chk({tag, " mask"}, 32'(bus.vote_mask), 0);
        chk({tag, " result"}, 32'(bus.result), 0);
        chk({tag, " valid"}, 32'(bus.result_valid), 0);
        chk({tag, " tflag"}, 32'(bus.timeout_flag), 0);
`ifdef VOTE_QUORUM_CHECK_EN
        chk({tag, " no_quorum"}, 32'(bus.no_quorum), 0);
`endif
    endtask

    // start a round with constant req/ballot and run until result_valid
    task automatic fixed_round(input logic [2:0] r, input logic [2:0] b);
        bus.start = 1'b1;
        bus.req = r;
        bus.ballot = b;
        @(negedge clk);
        bus.start = 1'b0;
        ncol = 0;
        while (bus.busy && !bus.result_valid && ncol < 40) begin
            gseq[ncol] = bus.gnt;
            ncol++;
            @(negedge clk);
        end
        chk("round reached result_valid", 32'(bus.result_valid), 1);
    endtask

    task automatic release_result();
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("release busy", 32'(bus.busy), 0);
        chk("release valid", 32'(bus.result_valid), 0);
    endtask

    function automatic logic [2:0] onehot(input int g);
        logic [2:0] v;
        v = 3'b000;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    int mptr;

    task automatic random_round();
        int g;
        int cyc;
        bit done;
        bit tout;
        bit voted [3];
        bit bal [3];
        logic [2:0] r;
        logic [2:0] b;
        logic [2:0] emask;
        int nv;
        int nb;
        int hold;
        bit eres;
        bus.start = 1'b1;
        bus.req = 3'($urandom);
        bus.ballot = 3'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        g = -1;
        cyc = 1;
        done = 0;
        tout = 0;
        for (int i = 0; i < 3; i++) begin
            voted[i] = 0;
            bal[i] = 0;
        end
        while (!done) begin
            chk("rand gnt", 32'(bus.gnt), 32'(onehot(g)));
            chk("rand busy", 32'(bus.busy), 1);
            r = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            bus.req = r;
            bus.ballot = b;
            bus.start = ($urandom_range(0, 3) == 0);
            if (g >= 0 && r[g]) begin
                voted[g] = 1;
                bal[g] = b[g];
                mptr = (g + 1) % 3;
            end
            if (voted[0] && voted[1] && voted[2]) begin
                done = 1;
            end else if (cyc == TO) begin
                done = 1;
                tout = 1;
            end else begin
                g = -1;
                for (int k = 0; k < 3; k++) begin
                    int idx;
                    idx = (mptr + k) % 3;
                    if (g < 0 && r[idx] && !voted[idx]) g = idx;
                end
            end
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("rand eval gnt", 32'(bus.gnt), 0);
        chk("rand eval valid", 32'(bus.result_valid), 0);
        @(negedge clk);
        nv = 0;
        nb = 0;
        for (int i = 0; i < 3; i++) begin
            emask[i] = voted[i];
            nv += int'(voted[i]);
            nb += int'(voted[i] && bal[i]);
        end
        eres = (nb >= 2);
        hold = $urandom_range(0, 3);
        for (int h = 0; h <= hold; h++) begin
            chk("rand valid", 32'(bus.result_valid), 1);
            chk("rand result", 32'(bus.result), 32'(eres));
            chk("rand mask", 32'(bus.vote_mask), 32'(emask));
            chk("rand tflag", 32'(bus.timeout_flag), 32'(tout));
`ifdef VOTE_QUORUM_CHECK_EN
            chk("rand no_quorum", 32'(bus.no_quorum), 32'(nv < 2));
`endif
            bus.start = ($urandom_range(0, 1) == 1);
            if (h < hold) @(negedge clk);
        end
        bus.start = 1'b0;
        release_result();
    endtask

    initial begin
        tbl[0] = '{3'b011, 3'b011, 3'b001, 16, 1'b1, 3'b011, 1'b1};
        tbl[1] = '{3'b111, 3'b110, 3'b100,  5, 1'b1, 3'b111, 1'b0};
        tbl[2] = '{3'b000, 3'b111, 3'b000, 16, 1'b0, 3'b000, 1'b1};
        tbl[3] = '{3'b101, 3'b111, 3'b100, 16, 1'b1, 3'b101, 1'b1};
        tbl[4] = '{3'b110, 3'b100, 3'b010, 16, 1'b0, 3'b110, 1'b1};
        tbl[5] = '{3'b001, 3'b001, 3'b001, 16, 1'b0, 3'b001, 1'b1};
        tbl[6] = '{3'b111, 3'b011, 3'b010,  5, 1'b1, 3'b111, 1'b0};
        tbl[7] = '{3'b111, 3'b100, 3'b010,  5, 1'b0, 3'b111, 1'b0};

        bus.start = 1'b0;
        bus.req = 3'b000;
        bus.ballot = 3'b000;
        bus.result_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post-reset idle");

        fixed_round(3'b111, 3'b101);
        chk("r1 cycles", 32'(ncol), 5);
        chk("r1 gnt c1", 32'(gseq[0]), 32'(3'b000));
        chk("r1 gnt c2", 32'(gseq[1]), 32'(3'b001));
        chk("r1 gnt c3", 32'(gseq[2]), 32'(3'b010));
        chk("r1 gnt c4", 32'(gseq[3]), 32'(3'b100));
        chk("r1 eval gnt", 32'(gseq[4]), 32'(3'b000));
        chk("r1 result", 32'(bus.result), 1);
        chk("r1 mask", 32'(bus.vote_mask), 32'(3'b111));
        chk("r1 tflag", 32'(bus.timeout_flag), 0);
        chk("r1 hold gnt", 32'(bus.gnt), 0);
        release_result();

        fixed_round(3'b111, 3'b010);
        chk("r2 gnt c2", 32'(gseq[1]), 32'(3'b001));
        chk("r2 gnt c3", 32'(gseq[2]), 32'(3'b010));
        chk("r2 gnt c4", 32'(gseq[3]), 32'(3'b100));
        chk("r2 result", 32'(bus.result), 0);
        chk("r2 mask", 32'(bus.vote_mask), 32'(3'b111));
        release_result();

        for (int i = 0; i < 8; i++) begin
            fixed_round(tbl[i].req, tbl[i].ballot);
            chk($sformatf("tbl%0d first gnt", i), 32'(gseq[1]),
                32'(tbl[i].first_gnt));
            chk($sformatf("tbl%0d cycles", i), 32'(ncol),
                32'(tbl[i].cycles));
            chk($sformatf("tbl%0d result", i), 32'(bus.result),
                32'(tbl[i].res));
            chk($sformatf("tbl%0d mask", i), 32'(bus.vote_mask),
                32'(tbl[i].mask));
            chk($sformatf("tbl%0d tflag", i), 32'(bus.timeout_flag),
                32'(tbl[i].tflag));
`ifdef VOTE_QUORUM_CHECK_EN
            chk($sformatf("tbl%0d no_quorum", i), 32'(bus.no_quorum),
                32'($countones(tbl[i].mask) < 2));
`endif
            release_result();
            chk($sformatf("tbl%0d mask held", i), 32'(bus.vote_mask),
                32'(tbl[i].mask));
            chk($sformatf("tbl%0d tflag held", i), 32'(bus.timeout_flag),
                32'(tbl[i].tflag));
        end

        // stalled consumer: outputs stable, start ignored
        fixed_round(3'b111, 3'b011);
        for (int h = 0; h < 5; h++) begin
            bus.start = h[0];
            @(negedge clk);
            chk("hold valid", 32'(bus.result_valid), 1);
            chk("hold result", 32'(bus.result), 1);
            chk("hold busy", 32'(bus.busy), 1);
        end
        bus.start = 1'b1;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.result_ready = 1'b0;
        chk("hold exit busy", 32'(bus.busy), 0);
        chk("hold exit valid", 32'(bus.result_valid), 0);
        @(negedge clk);
        chk("start at hold exit ignored", 32'(bus.busy), 0);

        // reset mid-round after one accept
        bus.start = 1'b1;
        bus.req = 3'b111;
        bus.ballot = 3'b111;
        @(negedge clk);
        bus.start = 1'b0;
        ncol = 0;
        while (bus.vote_mask == 3'b000 && ncol < 10) begin
            ncol++;
            @(negedge clk);
        end
        chk("pre-reset accepted one", 32'($countones(bus.vote_mask)), 1);
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid-round reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("after reset idle");
        fixed_round(3'b111, 3'b101);
        chk("fresh first gnt", 32'(gseq[1]), 32'(3'b001));
        chk("fresh result", 32'(bus.result), 1);
        release_result();

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mptr = 0;
        for (int n = 0; n < 60; n++) random_round();

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/vote_round_ctrl.md
Name: vote_round_ctrl

Overview:
- Sequences one shared 3-input majority evaluator among three voters.
- Runs one voting round per start pulse: round-robin grants each requesting voter, latches its ballot, evaluates majority (a&b | a&c | b&c) and presents the result through a valid/ready handshake.
- Sits between the voter front-ends and the downstream result consumer; its only datapath is the majority function.

Parameters:
TIMEOUT_CYCLES, 15, COLLECT cycles allowed before a round is force-closed; legal range 3..2^CNT_W-1
CNT_W, 4, width of the timeout counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a round; sampled only in IDLE
req  input  3  per-voter request to cast a ballot
ballot  input  3  per-voter ballot bit; bit i valid when gnt[i]&req[i]
gnt  output  3  registered grant, one-hot or zero
busy  output  1  high in any state other than IDLE
vote_mask  output  3  voters whose ballot was accepted this round
result  output  1  majority of latched ballots; missing ballots count as 0
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
timeout_flag  output  1  round closed by timeout; valid with result_valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, vote_mask=0, ballot regs=0, result=0, result_valid=0, timeout_flag=0, busy=0, rr_ptr=0, counter=0. Reset mid-round abandons the round; no partial result is emitted.
- States:
  - IDLE: start=1 -> COLLECT; clear vote_mask, ballot regs, counter, timeout_flag.
  - COLLECT: gnt=0 on the first cycle.
    - Each cycle: gnt_next = first set bit of (req & ~vote_mask_next), searching circularly from rr_ptr. Zero if none.
    - Accept: gnt[i]&req[i] -> ballot_reg[i]<=ballot[i], vote_mask[i]<=1, rr_ptr<=(i+1) mod 3.
    - The voter just accepted is excluded from gnt_next, so back-to-back grants are allowed.
    - Grant with req[i]=0: no accept; rearbitrate next cycle.
    - Counter increments every COLLECT cycle.
    - vote_mask_next==3'b111 -> EVAL.
    - Else counter==TIMEOUT_CYCLES-1 -> EVAL with timeout_flag<=1. All-voted takes priority over timeout in the same cycle.
  - EVAL: one cycle; gnt=0; result<=majority(ballot regs) -> HOLD.
  - HOLD: result_valid=1; result and timeout_flag stable. result_ready=1 -> IDLE next cycle, result_valid<=0.
- Latency: from the last accept to result_valid is 2 cycles.
- start outside IDLE: ignored, no queuing. start in the same cycle HOLD completes: ignored.
- req or ballot changes when not granted: no effect.
- rr_ptr persists across rounds, giving round-robin fairness between rounds.
- vote_mask and timeout_flag hold until the next start.

Optional Feature:
VOTE_QUORUM_CHECK_EN
- Defined: adds output no_quorum (1 bit, reset 0). It is set in EVAL when fewer than two bits of vote_mask are set, and is valid with result_valid. When no_quorum=1, result is forced to 0.
- Undefined: no_quorum port absent; result is always the plain majority with missing ballots as 0.

Test Plan:
- Reset, rr_ptr=0, start, req=111 held, ballot=101 -> gnt 000,001,010,100 on COLLECT cycles 1-4; EVAL; result_valid=1, result=1, vote_mask=111, timeout_flag=0.
- Second round, same stimulus, ballot=010 -> grant order 001,010,100 (rr_ptr wrapped to 0); result=0.
- req=011 only, ballot=011, TIMEOUT_CYCLES=15 -> two accepts, then timeout after 15 COLLECT cycles; timeout_flag=1, vote_mask=011, result=1.
- result_ready=0 for 5 cycles in HOLD -> result_valid and result stable; start pulses ignored; result_ready=1 -> IDLE, busy=0 next cycle.
- rst_n low during COLLECT after one accept -> all outputs 0 immediately; a following round behaves as fresh with rr_ptr=0.
- VOTE_QUORUM_CHECK_EN defined, req=001, ballot=001 -> timeout, no_quorum=1, result=0.
